// File: rtl/blake_nonce_scheduler.sv
// Nonce-sweep sequencer for a single BLAKE-512 core: issues one hash per nonce,
// compares each digest against the target and reports the first hit, range end or timeout.
module blake_nonce_scheduler #(
  parameter int CORE_TMO = 64,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             abort,
  input  logic [639:0]     hdr_tmpl,
  input  logic [31:0]      nonce_start,
  input  logic [31:0]      nonce_end,
  input  logic [511:0]     target,
  output logic             core_ena,
  output logic [639:0]     core_din,
  input  logic [511:0]     core_dout,
  input  logic             core_rdy,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [31:0]      found_nonce,
  output logic [511:0]     found_hash,
  output logic [CNT_W-1:0] hash_cnt
);

  localparam int TMR_W = $clog2(CORE_TMO + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [31:0]      nonce;
  logic [31:0]      nonce_end_l;
  logic [511:0]     target_l;
  logic [511:0]     digest;

  // The low header word is always overwritten by the nonce, so it is never stored.
  logic unused_hdr_bits;
  assign unused_hdr_bits = ^hdr_tmpl[31:0];

  // The upper 608 bits of core_din double as the latched header template.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= IDLE;
      timer       <= '0;
      nonce       <= '0;
      nonce_end_l <= '0;
      target_l    <= '0;
      digest      <= '0;
      core_ena    <= 1'b0;
      core_din    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      err         <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      hash_cnt    <= '0;
    end else begin
      core_ena <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            target_l    <= target;
            nonce_end_l <= nonce_end;
            nonce       <= nonce_start;
            core_din    <= {hdr_tmpl[639:32], nonce_start};
            found       <= 1'b0;
            err         <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            hash_cnt    <= '0;
            core_ena    <= 1'b1;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          if (abort) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (core_rdy) begin
            digest <= core_dout;
            if (hash_cnt != '1) hash_cnt <= hash_cnt + 1'b1;
            state  <= CHECK;
          end else if (timer == TMR_W'(CORE_TMO - 1)) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          if (abort) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (digest < target_l) begin
            found       <= 1'b1;
            found_nonce <= nonce;
            found_hash  <= digest;
            done        <= 1'b1;
            state       <= DONE;
          end else if (nonce == nonce_end_l) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            nonce          <= nonce + 32'd1;
            core_din[31:0] <= nonce + 32'd1;
            core_ena       <= 1'b1;
            state          <= ISSUE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blake_nonce_scheduler.sv
// Randomized scoreboard bench for blake_nonce_scheduler with a behavioural core model
// and a sweep-level reference model computing expected issues and job results.
module tb_blake_nonce_scheduler;

  localparam int CORE_TMO = 64;
  localparam int CNT_W    = 32;

  logic             clk;
  logic             rstb;
  logic             start;
  logic             abort;
  logic [639:0]     hdr_tmpl;
  logic [31:0]      nonce_start;
  logic [31:0]      nonce_end;
  logic [511:0]     target;
  logic             core_ena;
  logic [639:0]     core_din;
  logic [511:0]     core_dout;
  logic             core_rdy;
  logic             busy;
  logic             done;
  logic             found;
  logic             err;
  logic [31:0]      found_nonce;
  logic [511:0]     found_hash;
  logic [CNT_W-1:0] hash_cnt;

  blake_nonce_scheduler #(.CORE_TMO(CORE_TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstb(rstb), .start(start), .abort(abort),
    .hdr_tmpl(hdr_tmpl), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .target(target), .core_ena(core_ena), .core_din(core_din),
    .core_dout(core_dout), .core_rdy(core_rdy), .busy(busy), .done(done),
    .found(found), .err(err), .found_nonce(found_nonce),
    .found_hash(found_hash), .hash_cnt(hash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         found;
    logic         err;
    logic [31:0]  fnonce;
    logic [511:0] fhash;
    logic [31:0]  cnt;
  } res_t;

  res_t         exp_res_q[$];
  logic [31:0]  exp_issue_q[$];
  res_t         last_res;
  logic [639:0] exp_hdr;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur_mode = 0;
  int          cur_lat  = 1;
  int          rsp_mode = 0;
  int          cd       = 0;
  logic [31:0] job_key  = 32'h0;
  logic [31:0] pend_n   = 32'h0;

  // Core digest behaviour: 0 all-ones, 1 zero, 2 nonce-dependent pseudo hash, 3 zero only at nonce 0.
  function automatic logic [511:0] digest_of(input int mode, input logic [31:0] n);
    logic [31:0] h;
    h = (n * 32'h9E37_79B1) ^ job_key;
    case (mode)
      0:       return '1;
      1:       return '0;
      2:       return {h, {15{h ^ 32'hA5A5_0F0F}}};
      default: return (n == 32'h0) ? 512'h0 : '1;
    endcase
  endfunction

  task automatic check_output(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Sweep reference model, then one start pulse; returns on the negedge where core_ena should show.
  task automatic apply_stimulus(input logic [31:0] s, input logic [31:0] e, input logic [511:0] tgt,
                                input int mode, input int lat, input bit aborted);
    res_t         r;
    logic [31:0]  n;
    logic [511:0] d;
    cur_mode = mode;
    cur_lat  = lat;
    for (int i = 0; i < 20; i++) exp_hdr[i*32 +: 32] = $urandom();
    r.found = 1'b0; r.err = 1'b0; r.fnonce = '0; r.fhash = '0; r.cnt = '0;
    n = s;
    if (aborted) begin
      exp_issue_q.push_back(s);
    end else begin
      for (int i = 0; i < 4096; i++) begin
        exp_issue_q.push_back(n);
        if (lat > CORE_TMO) begin
          r.err = 1'b1;
          break;
        end
        r.cnt++;
        d = digest_of(mode, n);
        if (d < tgt) begin
          r.found = 1'b1; r.fnonce = n; r.fhash = d;
          break;
        end
        if (n == e) break;
        n = n + 32'd1;
      end
    end
    exp_res_q.push_back(r);
    last_res = r;
    @(negedge clk);
    hdr_tmpl = exp_hdr; nonce_start = s; nonce_end = e; target = tgt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < budget);
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL done_wait: no done within %0d cycles", budget);
    end
  endtask

  // Core model: core_rdy pulses cur_lat cycles after the core_ena cycle.
  always @(negedge clk) begin
    core_rdy = 1'b0;
    if (!rstb) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          core_rdy  = 1'b1;
          core_dout = digest_of(rsp_mode, pend_n);
        end
      end
      if (core_ena) begin
        cd       = cur_lat;
        pend_n   = core_din[31:0];
        rsp_mode = cur_mode;
      end
    end
  end

  // Scoreboard monitor: compares each issue and each job result against the queued expectations.
  logic [31:0] mon_nonce;
  res_t        mon_res;
  always @(negedge clk) begin
    if (rstb) begin
      if (core_ena) begin
        if (exp_issue_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL issue: unexpected core_ena with nonce %0h", core_din[31:0]);
        end else begin
          mon_nonce = exp_issue_q.pop_front();
          check_output("issue_nonce", 640'(core_din[31:0]), 640'(mon_nonce));
          check_output("issue_hdr", 640'(core_din[639:32]), 640'(exp_hdr[639:32]));
        end
      end
      if (done) begin
        if (exp_res_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL result: unexpected done pulse");
        end else begin
          mon_res = exp_res_q.pop_front();
          check_output("found", 640'(found), 640'(mon_res.found));
          check_output("err", 640'(err), 640'(mon_res.err));
          check_output("found_nonce", 640'(found_nonce), 640'(mon_res.fnonce));
          check_output("found_hash", 640'(found_hash), 640'(mon_res.fhash));
          check_output("hash_cnt", 640'(hash_cnt), 640'(mon_res.cnt));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [511:0] t;
    logic [31:0]  s;
    logic [31:0]  e;
    int           cyc;
    int           len;
    int           lat;
    int           k;

    rstb = 1'b0; start = 1'b0; abort = 1'b0;
    hdr_tmpl = '0; nonce_start = '0; nonce_end = '0; target = '0;
    core_dout = '0;
    exp_hdr = '0;
    #12;
    check_output("rst_busy", 640'(busy), 640'(0));
    check_output("rst_done", 640'(done), 640'(0));
    check_output("rst_ena", 640'(core_ena), 640'(0));
    check_output("rst_din", core_din, 640'(0));
    check_output("rst_found", 640'(found), 640'(0));
    check_output("rst_err", 640'(err), 640'(0));
    check_output("rst_hash_cnt", 640'(hash_cnt), 640'(0));
    @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] hit on first nonce");
    t = '0; t[500] = 1'b1;
    apply_stimulus(32'h10, 32'h20, t, 1, 20, 1'b0);
    wait_done(200, cyc);
    check_output("hit_latency", 640'(cyc), 640'(20 + 2));
    @(negedge clk);

    $display("[TB] full miss with start while busy");
    apply_stimulus(32'd5, 32'd9, t, 0, 6, 1'b0);
    repeat (3) @(negedge clk);
    hdr_tmpl = '1; nonce_start = 32'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(200, cyc);
    @(negedge clk);

    $display("[TB] wrap");
    t = 512'd1;
    apply_stimulus(32'hFFFF_FFFE, 32'h1, t, 3, 7, 1'b0);
    wait_done(200, cyc);
    repeat (10) @(negedge clk);
    check_output("hold_found_nonce", 640'(found_nonce), 640'(last_res.fnonce));
    check_output("hold_hash_cnt", 640'(hash_cnt), 640'(last_res.cnt));
    check_output("hold_found", 640'(found), 640'(last_res.found));

    $display("[TB] rdy on last timer cycle");
    apply_stimulus(32'h77, 32'h77, t, 1, CORE_TMO, 1'b0);
    wait_done(300, cyc);
    check_output("edge_latency", 640'(cyc), 640'(CORE_TMO + 2));
    @(negedge clk);

    $display("[TB] timeout");
    t = '0;
    apply_stimulus(32'h40, 32'h50, t, 0, 80, 1'b0);
    wait_done(300, cyc);
    check_output("tmo_latency", 640'(cyc), 640'(CORE_TMO + 1));
    @(negedge clk);
    check_output("tmo_busy_after", 640'(busy), 640'(0));
    repeat (30) @(negedge clk);
    check_output("late_rdy_busy", 640'(busy), 640'(0));
    check_output("late_rdy_err", 640'(err), 640'(1));
    check_output("late_rdy_cnt", 640'(hash_cnt), 640'(0));

    $display("[TB] abort during wait");
    t = '1;
    apply_stimulus(32'h300, 32'h310, t, 1, 30, 1'b1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_done", 640'(done), 640'(1));
    check_output("abort_found", 640'(found), 640'(0));
    check_output("abort_err", 640'(err), 640'(0));
    repeat (40) @(negedge clk);
    check_output("abort_late_busy", 640'(busy), 640'(0));
    check_output("abort_late_cnt", 640'(hash_cnt), 640'(0));

    $display("[TB] start and abort together in idle");
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check_output("collide_busy", 640'(busy), 640'(0));

    $display("[TB] reset mid-job");
    t = '0;
    apply_stimulus(32'h0, 32'h9, t, 0, 5, 1'b0);
    k = 0;
    while (hash_cnt < 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_output("pre_reset_cnt", 640'(hash_cnt), 640'(2));
    repeat (3) @(negedge clk);
    #2 rstb = 1'b0;
    #1;
    check_output("mid_rst_busy", 640'(busy), 640'(0));
    check_output("mid_rst_ena", 640'(core_ena), 640'(0));
    check_output("mid_rst_din", core_din, 640'(0));
    check_output("mid_rst_cnt", 640'(hash_cnt), 640'(0));
    check_output("mid_rst_done", 640'(done), 640'(0));
    exp_issue_q.delete();
    exp_res_q.delete();
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    $display("[TB] randomized jobs");
    for (int j = 0; j < 12; j++) begin
      s   = (j % 3 == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 6)) : $urandom();
      len = $urandom_range(1, 12);
      e   = s + 32'(len - 1);
      lat = $urandom_range(1, 12);
      job_key = $urandom();
      t = '0;
      t[511:480] = 32'($urandom_range(0, 32'h0FFF_FFFF));
      apply_stimulus(s, e, t, 2, lat, 1'b0);
      wait_done(len * (lat + 4) + 20, cyc);
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check_output("issue_q_empty", 640'(exp_issue_q.size()), 640'(0));
    check_output("result_q_empty", 640'(exp_res_q.size()), 640'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
